// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, with a one-entry holding register
// so a new byte can be queued while the current frame is on the line.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s). Default build has no parity.
// Serial, active and done outputs are registered, so the line lags the FSM
// state by one clock.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       i_clock,
    input  logic       i_rst_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    // Terminal counts for one bit period and for the whole stop field.
    localparam logic [8:0] BIT_LAST  = 9'(CLKS_PER_BIT - 1);
    localparam logic [8:0] STOP_LAST = 9'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_CLEANUP
    } state_t;

    state_t     r_state;
    logic [8:0] r_clk_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_hold_byte;
    logic       r_hold_valid;
    logic       r_serial;
    logic       r_active;
    logic       r_done;

    logic       w_accept;
    logic       w_load;
    logic       w_bit_end;
    logic       w_stop_end;

    // Accept only into an empty holding register; the FSM drains it from
    // IDLE or straight from CLEANUP so back-to-back frames need no idle gap.
    assign w_accept   = i_Tx_DV && !r_hold_valid;
    assign w_load     = r_hold_valid && ((r_state == S_IDLE) || (r_state == S_CLEANUP));
    assign w_bit_end  = (r_clk_cnt == BIT_LAST);
    assign w_stop_end = (r_clk_cnt == STOP_LAST);

    assign o_Tx_Ready  = !r_hold_valid;
    assign o_Tx_Serial = r_serial;
    assign o_Tx_Active = r_active;
    assign o_Tx_Done   = r_done;

    // Holding register: filled on handshake, emptied when the FSM loads it.
    // Accept needs an empty register and load needs a full one, so the two
    // never coincide and a queued byte is never overwritten.
    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_byte  <= '0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_byte  <= i_Tx_Byte;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Frame sequencer with registered line, active and done outputs.
    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_serial  <= 1'b1;
                    r_active  <= 1'b0;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (w_load) begin
                        r_shift <= r_hold_byte;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    r_serial <= 1'b0;
                    r_active <= 1'b1;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 9'd1;
                    end
                end

                S_DATA: begin
                    r_serial <= r_shift[r_bit_idx];
                    r_active <= 1'b1;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 9'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    r_serial <= ^r_shift;
                    r_active <= 1'b1;
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 9'd1;
                    end
                end
`endif

                S_STOP: begin
                    r_serial <= 1'b1;
                    r_active <= 1'b1;
                    if (w_stop_end) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_CLEANUP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 9'd1;
                    end
                end

                S_CLEANUP: begin
                    r_serial  <= 1'b1;
                    r_active  <= 1'b0;
                    r_done    <= 1'b1;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (w_load) begin
                        r_shift <= r_hold_byte;
                        r_state <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Two instances share the clock
// and reset: STOP_BITS=1 and STOP_BITS=2, both at CLKS_PER_BIT=4. Expected
// line behaviour comes from a frame model (slot k of a frame -> bit value).
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       dv0   = 1'b0;
    logic [7:0] byte0 = '0;
    logic       rdy0, ser0, act0, done0;

    logic       dv1   = 1'b0;
    logic [7:0] byte1 = '0;
    logic       rdy1, ser1, act1, done1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
        .i_clock    (clk),
        .i_rst_n    (rst_n),
        .i_Tx_DV    (dv0),
        .i_Tx_Byte  (byte0),
        .o_Tx_Ready (rdy0),
        .o_Tx_Serial(ser0),
        .o_Tx_Active(act0),
        .o_Tx_Done  (done0)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
        .i_clock    (clk),
        .i_rst_n    (rst_n),
        .i_Tx_DV    (dv1),
        .i_Tx_Byte  (byte1),
        .o_Tx_Ready (rdy1),
        .o_Tx_Serial(ser1),
        .o_Tx_Active(act1),
        .o_Tx_Done  (done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int n_slots(input int sel);
        return 1 + 8 + PAR + ((sel == 0) ? 1 : 2);
    endfunction

    function automatic int frame_len(input int sel);
        return CPB * n_slots(sel);
    endfunction

    // Bit value of slot k: start, 8 data LSB first, optional even parity, stops.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR == 1 && k == 9) return (($countones(b) % 2) == 1);
        return 1'b1;
    endfunction

    // {serial, active, done, ready}
    function automatic logic [3:0] sample(input int sel);
        if (sel == 0) return {ser0, act0, done0, rdy0};
        return {ser1, act1, done1, rdy1};
    endfunction

    task automatic drive(input int sel, input logic dv, input logic [7:0] b);
        if (sel == 0) begin
            dv0 = dv; byte0 = b;
        end else begin
            dv1 = dv; byte1 = b;
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the acceptance edge.
    task automatic accept(input int sel, input logic [7:0] b, output int acc_cyc);
        logic [3:0] s;
        s = sample(sel);
        n_tests++;
        if (s[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready dut%0d: ready=%b expected 1 before presenting %h", sel, s[0], b);
        end
        drive(sel, 1'b1, b);
        @(posedge clk); #1;
        acc_cyc = cyc;
        drive(sel, 1'b0, 8'($urandom));
    endtask

    // Cycle-exact check of the line from the acceptance edge of q[0]:
    // two idle-high cycles, then each frame followed by one done/cleanup cycle.
    task automatic check_frames(input int sel, input logic [7:0] q[$], input string tag);
        logic [3:0] s;
        logic [2:0] exp;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk); s = sample(sel); exp = 3'b100;
            n_tests++;
            if (s[3:1] !== exp) begin
                n_fail++;
                $display("FAIL %s lead %0d: serial/active/done=%b expected %b", tag, t, s[3:1], exp);
            end
        end
        foreach (q[f]) begin
            for (int k = 0; k < n_slots(sel); k++) begin
                for (int j = 0; j < CPB; j++) begin
                    @(negedge clk); s = sample(sel);
                    exp = {frame_bit(q[f], k), 1'b1, 1'b0};
                    n_tests++;
                    if (s[3:1] !== exp) begin
                        n_fail++;
                        $display("FAIL %s byte %h slot %0d cycle %0d: serial/active/done=%b expected %b",
                                 tag, q[f], k, j, s[3:1], exp);
                    end
                end
            end
            @(negedge clk); s = sample(sel); exp = 3'b101;
            n_tests++;
            if (s[3:1] !== exp) begin
                n_fail++;
                $display("FAIL %s cleanup after %h: serial/active/done=%b expected %b", tag, q[f], s[3:1], exp);
            end
        end
        @(negedge clk); s = sample(sel); exp = 3'b100;
        n_tests++;
        if (s[3:1] !== exp) begin
            n_fail++;
            $display("FAIL %s trailing idle: serial/active/done=%b expected %b", tag, s[3:1], exp);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0] s;
        rst_n = 1'b0;
        drive(0, 1'b1, 8'hAA);
        drive(1, 1'b1, 8'h55);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            s = sample(sel);
            n_tests++;
            if (s !== 4'b1001) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: serial/active/done/ready=%b expected 1001", sel, s);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            for (int sel = 0; sel < 2; sel++) begin
                s = sample(sel);
                n_tests++;
                if (s !== 4'b1001) begin
                    n_fail++;
                    $display("FAIL post_reset_idle dut%0d t%0d: %b expected 1001", sel, t, s);
                end
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] dir [5];
        dir = '{8'hA5, 8'h07, 8'h03, 8'h00, 8'hFF};
        for (int i = 0; i < 11; i++) begin
            logic [7:0] b;
            logic [7:0] q[$];
            int n;
            int act_cnt;
            int done_cnt;
            b = (i < 5) ? dir[i] : 8'($urandom);
            q.delete();
            q.push_back(b);
            @(posedge clk); #1;
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
            end
            accept(0, b, n);
            act_cnt = 0;
            done_cnt = 0;
            fork
                check_frames(0, q, "single");
                begin
                    repeat (frame_len(0) + 4) begin
                        @(negedge clk);
                        if (act0 === 1'b1) act_cnt++;
                        if (done0 === 1'b1) done_cnt++;
                    end
                end
            join
            n_tests++;
            if (act_cnt !== frame_len(0)) begin
                n_fail++;
                $display("FAIL active_len byte %h: %0d cycles expected %0d", b, act_cnt, frame_len(0));
            end
            n_tests++;
            if (done_cnt !== 1) begin
                n_fail++;
                $display("FAIL done_pulses byte %h: %0d expected 1", b, done_cnt);
            end
        end
    endtask

    task automatic b2b_pair(input logic [7:0] a, input logic [7:0] b, input int d, input string tag);
        logic [7:0] q[$];
        int n;
        int m;
        int low;
        int exp_low;
        q.push_back(a);
        q.push_back(b);
        @(posedge clk); #1;
        accept(0, a, n);
        fork
            check_frames(0, q, tag);
            begin
                repeat (d) @(posedge clk);
                #1;
                accept(0, b, m);
                low = 0;
                for (int t = 0; t < 4 * frame_len(0); t++) begin
                    @(negedge clk);
                    if (rdy0 !== 1'b0) break;
                    low++;
                end
                exp_low = n + 2 + frame_len(0) - m;
                n_tests++;
                if (low !== exp_low) begin
                    n_fail++;
                    $display("FAIL %s ready_low: %0d cycles expected %0d", tag, low, exp_low);
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        b2b_pair(8'h00, 8'hFF, 1 + 3 * CPB, "b2b_directed");
        b2b_pair(8'($urandom), 8'($urandom), 1, "b2b_earliest");
        b2b_pair(8'($urandom), 8'($urandom), frame_len(0), "b2b_latest");
        for (int i = 0; i < 3; i++)
            b2b_pair(8'($urandom), 8'($urandom), $urandom_range(1, frame_len(0)), "b2b_random");
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        int n;
        int sent;
        int iter;
        logic r;
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        @(posedge clk); #1;
        accept(0, q[0], n);
        fork
            check_frames(0, q, "backpressure");
            begin
                sent = 1;
                iter = 0;
                while (sent < 3 && iter < 4 * frame_len(0)) begin
                    r = rdy0;
                    dv0 = 1'b1;
                    byte0 = r ? q[sent] : 8'($urandom);
                    @(posedge clk); #1;
                    if (r) sent++;
                    iter++;
                end
                dv0 = 1'b0;
                n_tests++;
                if (sent !== 3) begin
                    n_fail++;
                    $display("FAIL backpressure_handshakes: %0d accepted expected 3", sent);
                end
            end
        join
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        logic [7:0] q[$];
        logic [3:0] s;
        logic [2:0] exp;
        int n;
        int t_end;
        b = 8'h3C;
        @(posedge clk); #1;
        accept(0, b, n);
        t_end = 2 + 4 * CPB + 2;
        for (int t = 0; t < t_end; t++) begin
            @(negedge clk); s = sample(0);
            exp = (t < 2) ? 3'b100 : {frame_bit(b, (t - 2) / CPB), 1'b1, 1'b0};
            n_tests++;
            if (s[3:1] !== exp) begin
                n_fail++;
                $display("FAIL midframe_prefix t%0d: serial/active/done=%b expected %b", t, s[3:1], exp);
            end
        end
        rst_n = 1'b0;
        dv0 = 1'b1;
        byte0 = 8'h55;
        @(negedge clk); s = sample(0);
        n_tests++;
        if (s !== 4'b1001) begin
            n_fail++;
            $display("FAIL midframe_reset: serial/active/done/ready=%b expected 1001", s);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dv0 = 1'b0;
        for (int t = 0; t < frame_len(0) + 4; t++) begin
            @(negedge clk); s = sample(0);
            n_tests++;
            if (s !== 4'b1001) begin
                n_fail++;
                $display("FAIL midframe_aftermath t%0d: serial/active/done/ready=%b expected 1001", t, s);
            end
        end
        b = 8'($urandom);
        q.push_back(b);
        @(posedge clk); #1;
        accept(0, b, n);
        check_frames(0, q, "after_reset");
    endtask

    task automatic test_stop_bits();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] q[$];
            int n;
            q.delete();
            q.push_back((i == 0) ? 8'h5A : 8'($urandom));
            @(posedge clk); #1;
            accept(1, q[0], n);
            check_frames(1, q, "stop2");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_stop_bits();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
